// File: rtl/next_kbd_link.sv
// next_kbd_link: NeXT keyboard/mouse serial link engine (monitor clock domain).
// Runs the reset / query / LED command schedule on to_kb and validates the
// 21-bit responses on from_kb. Decoded key and mouse events go into a
// first-word-fall-through FIFO.
// Optional feature macro: NEXT_KBD_MOUSE_EN. When defined, queries alternate
// between keyboard and mouse. When undefined, only keyboard queries are sent.
// Ports:
//   clk, rst_n           monitor clock, asynchronous active-low reset
//   led_valid, led_data  one-cycle strobe latching the 2 LED bits to send
//   rd_en                pop the FIFO head (ignored while fifo_empty)
//   fifo_empty           no queued events
//   fifo_dout            {is_mouse, data[15:0]} of the FIFO head, 0 when empty
//   overflow             sticky, set when an event is dropped on a full FIFO
//   link_ready           keyboard has answered the reset handshake
//   from_kb / to_kb      serial lines to and from the keyboard, idle high
module next_kbd_link #(
  parameter int unsigned BIT_CYCLES = 1431,
  parameter int unsigned FRAME_BITS = 40,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_MISS   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_valid,
  input  logic [1:0]  led_data,
  input  logic        rd_en,
  output logic        fifo_empty,
  output logic [16:0] fifo_dout,
  output logic        overflow,
  output logic        link_ready,
  input  logic        from_kb,
  output logic        to_kb
);
  localparam int unsigned BW   = $clog2(BIT_CYCLES);
  localparam int unsigned FW   = $clog2(FRAME_BITS);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned HALF = BIT_CYCLES / 2;
  localparam logic [20:0] RST_PKT = 21'b111101111110000000000;

  typedef enum logic [1:0] {LINK_RESET, LINK_PENDING, LINK_UP} link_t;

  logic [BW-1:0] bit_cnt, rx_tmr;
  logic [FW-1:0] frm_cnt;
  logic          tick, frame_start;
  logic          sync1, rx_s;
  link_t         link_st, st_eff;
  logic [3:0]    miss, miss_eff;
  logic [20:0]   pkt, tx_sr, rx_sr;
  logic [4:0]    pkt_len, tx_left, rx_cnt;
  logic          pkt_query, pkt_led;
  logic          tx_busy, tx_query, frm_query, got_valid;
  logic          led_pend;
  logic [1:0]    led_val;
  logic          rx_win, rx_act, rx_done, rx_fin;
  logic          push;
  logic [16:0]   push_data;
  logic          is_ready, is_data;
`ifdef NEXT_KBD_MOUSE_EN
  logic          query_mouse, win_mouse;
`else
  logic          win_mouse;
  assign win_mouse = 1'b0;
`endif

  assign tick        = (bit_cnt == BW'(BIT_CYCLES - 1));
  assign frame_start = tick && (frm_cnt == FW'(FRAME_BITS - 1));
  assign is_ready    = (rx_sr ==? 21'b10000000001100000000?);
  assign is_data     = !rx_sr[20] && (rx_sr[11:9] == 3'b010);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sync1, rx_s} <= 2'b11;
      bit_cnt       <= '0;
      frm_cnt       <= '0;
    end else begin
      {sync1, rx_s} <= {from_kb, sync1};
      bit_cnt       <= tick ? '0 : bit_cnt + BW'(1);
      if (tick) frm_cnt <= frame_start ? '0 : frm_cnt + FW'(1);
    end
  end

  // Frame-start decision: account for the frame just ending first, so a
  // miss that exhausts the budget sends the reset packet in this very frame.
  always_comb begin
    st_eff    = link_st;
    miss_eff  = miss;
    pkt       = '0;
    pkt_len   = '0;
    pkt_query = 1'b0;
    pkt_led   = 1'b0;
    if (frm_query && !got_valid) begin
      if (({1'b0, miss} + 5'd1) >= 5'(MAX_MISS)) begin
        st_eff   = LINK_RESET;
        miss_eff = '0;
      end else begin
        miss_eff = miss + 4'd1;
      end
    end
    if (st_eff == LINK_RESET) begin
      pkt     = RST_PKT;
      pkt_len = 5'd21;
    end else if (st_eff == LINK_UP && led_pend && !led_valid) begin
      pkt     = {12'b000000001110, led_val, 7'b0};
      pkt_len = 5'd21;
      pkt_led = 1'b1;
    end else begin
`ifdef NEXT_KBD_MOUSE_EN
      pkt = {(query_mouse ? 8'b10001000 : 8'b00001000), 13'b0};
`else
      pkt = {8'b00001000, 13'b0};
`endif
      pkt_len   = 5'd8;
      pkt_query = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_st    <= LINK_RESET;
      miss       <= '0;
      link_ready <= 1'b0;
      to_kb      <= 1'b1;
      tx_sr      <= '0;
      tx_left    <= '0;
      tx_busy    <= 1'b0;
      tx_query   <= 1'b0;
      frm_query  <= 1'b0;
      got_valid  <= 1'b0;
      led_pend   <= 1'b0;
      led_val    <= '0;
      rx_win     <= 1'b0;
      rx_act     <= 1'b0;
      rx_done    <= 1'b0;
      rx_fin     <= 1'b0;
      rx_cnt     <= '0;
      rx_tmr     <= '0;
      rx_sr      <= '0;
      push       <= 1'b0;
      push_data  <= '0;
`ifdef NEXT_KBD_MOUSE_EN
      query_mouse <= 1'b0;
      win_mouse   <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      if (led_valid) begin
        led_val  <= led_data;
        led_pend <= 1'b1;
      end
      if (frame_start) begin
        link_st <= (st_eff == LINK_RESET) ? LINK_PENDING : st_eff;
        miss    <= miss_eff;
        if (st_eff == LINK_RESET) link_ready <= 1'b0;
        if (pkt_led) led_pend <= 1'b0;
        to_kb     <= 1'b0;
        tx_sr     <= pkt;
        tx_left   <= pkt_len;
        tx_busy   <= 1'b1;
        tx_query  <= pkt_query;
        frm_query <= pkt_query;
        got_valid <= 1'b0;
        rx_win    <= 1'b0;
        rx_act    <= 1'b0;
        rx_done   <= 1'b0;
        rx_fin    <= 1'b0;
`ifdef NEXT_KBD_MOUSE_EN
        if (pkt_query) begin
          win_mouse   <= query_mouse;
          query_mouse <= ~query_mouse;
        end
`endif
      end else begin
        if (tick && tx_busy) begin
          if (tx_left != 5'd0) begin
            to_kb   <= tx_sr[20];
            tx_sr   <= {tx_sr[19:0], 1'b0};
            tx_left <= tx_left - 5'd1;
          end else begin
            to_kb   <= 1'b1;
            tx_busy <= 1'b0;
            if (tx_query) rx_win <= 1'b1;
          end
        end
        // rx_cnt 0 is the start-bit check; 1..21 are the data samples.
        if (rx_act) begin
          if (rx_tmr != '0) begin
            rx_tmr <= rx_tmr - BW'(1);
          end else begin
            rx_tmr <= BW'(BIT_CYCLES - 1);
            if (rx_cnt == 5'd0) begin
              if (rx_s) rx_act <= 1'b0;
              else      rx_cnt <= 5'd1;
            end else begin
              rx_sr <= {rx_s, rx_sr[20:1]};
              if (rx_cnt == 5'd21) begin
                rx_act  <= 1'b0;
                rx_done <= 1'b1;
                rx_fin  <= 1'b1;
              end else begin
                rx_cnt <= rx_cnt + 5'd1;
              end
            end
          end
        end else if (rx_win && !rx_done && !rx_s) begin
          rx_act <= 1'b1;
          rx_cnt <= 5'd0;
          rx_tmr <= BW'(HALF - 1);
        end
        if (rx_fin) begin
          rx_fin <= 1'b0;
          if (link_st == LINK_PENDING && is_ready) begin
            link_st    <= LINK_UP;
            link_ready <= 1'b1;
            miss       <= '0;
            got_valid  <= 1'b1;
          end else if (link_st == LINK_UP && (is_ready || is_data)) begin
            miss      <= '0;
            got_valid <= 1'b1;
            push      <= is_data;
            push_data <= {win_mouse, rx_sr[19:12], rx_sr[8:1]};
          end
        end
      end
    end
  end

  logic [16:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, wr_ok;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = rd_en && !fifo_empty;
  assign wr_ok      = push && (!full || pop);
  assign fifo_dout  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule
